uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Serial-to-parallel UART receive deframer. It sits between the asynchronous `rx` pad and the receive FIFO, and is driven by the 16x oversampling tick from the baud timer. It detects a start bit, samples each data bit at mid-bit, checks optional parity and the stop bit, then delivers one byte per frame with error flags. It is the receiving counterpart of the UART transmit serializer and shares its tick source and frame format.

## Interface
- `n_data_bits`, 8: data bits per frame, LSB first.
- `sb_ticks`, 16: stop-bit length in s_ticks (16 = 1 stop bit, 32 = 2).
- `parity_en`, 0: 1 adds one parity bit after the data bits.
- `parity_odd`, 0: 1 = odd parity, 0 = even. Ignored when `parity_en` = 0.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s_tick` in 1: one-clk pulse at 16x the baud rate, from the baud timer.
- `rx` in 1: asynchronous serial line, idle high.
- `dout` out `n_data_bits`: last received data word.
- `rx_done_tick` out 1: one-clk pulse marking a completed frame. `dout` and the error flags are valid in the same cycle.
- `parity_err` out 1: parity mismatch on the last frame.
- `framing_err` out 1: stop bit sampled low on the last frame.
- `break_det` out 1: last frame was a line break.
- `busy` out 1: high in every state except idle.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`). Both flops reset to 1.
- Counters:
  - `s`: tick count, wide enough for `sb_ticks`-1.
  - `n`: bit index, log2(`n_data_bits`) bits.
  - `b`: shift register.
- Counters advance only on cycles where `s_tick` = 1.
- FSM states and transitions:
  - **IDLE**: when `rx_s` = 0, clear `s` and go to START. This check does not wait for `s_tick`.
  - **START**: when `s` = 7, if `rx_s` = 0 clear `s`, clear `n` and go to DATA. Otherwise the low pulse was a glitch: go to IDLE with no pulse. Below 7, increment `s`.
  - **DATA**: when `s` = 15, clear `s` and shift: `b` <= {`rx_s`, `b`[msb:1]}. If `n` = `n_data_bits`-1, go to PARITY when `parity_en` = 1, else STOP. Otherwise increment `n`.
  - **PARITY**: when `s` = 15, capture `rx_s` as `pbit`, clear `s`, go to STOP.
  - **STOP**: when `s` = `sb_ticks`-1:
    - Register all outputs and pulse `rx_done_tick`.
    - `framing_err` = ~`rx_s`.
    - `parity_err` = `parity_en` & (^`b` ^ `pbit` ^ `parity_odd`).
    - `break_det` = (`b` = 0) & ~`rx_s` & (`pbit` = 0 or `parity_en` = 0).
    - Next state: IDLE if `rx_s` = 1, else WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s` = 1, then go to IDLE. This stops a held-low line from retriggering.
- `dout` and all three error flags hold their values until the next `rx_done_tick`.
- Reset mid-frame aborts the frame: return to IDLE, no `rx_done_tick`, outputs return to their reset values.

## Timing
- Reset values:
  - `dout` = 0.
  - `rx_done_tick`, `parity_err`, `framing_err`, `break_det`, `busy` = 0.
  - State = IDLE.
  - `rx_s` = 1.
- Detection latency: a falling edge on `rx` is seen by the FSM 2 clk later.
- Sampling: data bits are sampled at tick 8 of each bit (mid-bit), measured from the start-bit edge.
- `rx_done_tick` is high for exactly 1 clk, in the cycle after the `s_tick` that completes STOP. It is registered.
- Frame length: 16·(1 + `n_data_bits` + `parity_en`) − 8 + `sb_ticks` ticks from the start edge. For 8N1 that is 152 ticks.
- Back-to-back frames: a start edge seen in the cycle after `rx_done_tick` is accepted.
- `busy` rises 1 clk after `rx_s` falls. It drops in the cycle `rx_done_tick` is asserted, or on glitch rejection.

## Structure
- Shared header `uart_defs.vh`:
  - State encodings (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - `OVERSAMPLE` = 16.
  - `MID_TICK` = 7.
  - The same header is used by the transmit serializer.
- One sub-module: `uart_sync2`, the 2-FF synchronizer with a reset value parameter.

## Test plan
Bench `s_tick` runs every 4 clk; `rx` is driven with bit time = 64 clk.
- **8N1 stream**: send 0xA5, then 100, 150 and 200 back-to-back → exactly four `rx_done_tick` pulses, `dout` = A5/64/96/C8 in order, all error flags 0.
- **Glitch**: `rx` low for 5 ticks, then high → no `rx_done_tick`, `busy` returns to 0 within 2 ticks of tick 7.
- **Bad stop bit**: 0x3C with stop bit low, `rx` high 2 bit times later → `dout` = 0x3C, `framing_err` = 1, `break_det` = 0; the next frame 0x11 is received clean.
- **Break**: `rx` low for 12 bit times → exactly one pulse with `dout` = 0, `framing_err` = 1, `break_det` = 1; no further pulse until `rx` returns high.
- **Parity**: `parity_en` = 1, `parity_odd` = 0. Send 0x07 with pbit 1 → `parity_err` = 0. Send 0x07 with pbit 0 → `parity_err` = 1.
- **Reset mid-frame**: assert `reset` for 1 clk during data bit 3 of 0xF0 → no pulse, all outputs 0; the following frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// The same package serves the receive deframer and the transmit serializer
// so both sides agree on frame timing.
package uart_rx_deframer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_state_t;

   localparam int OVERSAMPLE = 16;  // s_ticks per bit
   localparam int MID_TICK   = 7;   // start-bit check point (mid start bit)

endpackage

// File: rtl/uart_rx_deframer_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output (2 clk latency)
module uart_rx_deframer_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer, 16x oversampled. Finds the start bit, samples each
// data bit mid-bit, checks optional parity and the stop bit, and delivers one
// word per frame with error flags.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   s_tick        - 16x baud tick (one clk wide)
//   rx            - asynchronous serial line, idle high
//   dout          - last received word (held until next frame)
//   rx_done_tick  - one-clk pulse, dout and flags valid in the same cycle
//   parity_err    - parity mismatch on last frame
//   framing_err   - stop bit sampled low on last frame
//   break_det     - last frame was a line break
//   busy          - high whenever the FSM is not idle
module uart_rx_deframer
   import uart_rx_deframer_pkg::*;
#(
   parameter int n_data_bits = 8,
   parameter int sb_ticks    = 16,
   parameter bit parity_en   = 1'b0,
   parameter bit parity_odd  = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_tick,
   input  logic                   rx,
   output logic [n_data_bits-1:0] dout,
   output logic                   rx_done_tick,
   output logic                   parity_err,
   output logic                   framing_err,
   output logic                   break_det,
   output logic                   busy
);

   // s must reach both OVERSAMPLE-1 and sb_ticks-1
   localparam int SW = ($clog2(sb_ticks) > 4) ? $clog2(sb_ticks) : 4;
   localparam int NW = (n_data_bits > 1) ? $clog2(n_data_bits) : 1;

   localparam logic [SW-1:0] S_MID       = SW'(MID_TICK);
   localparam logic [SW-1:0] S_LAST_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_LAST_STOP = SW'(sb_ticks - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(n_data_bits - 1);

   uart_state_t            state;
   logic [SW-1:0]          s;
   logic [NW-1:0]          n;
   logic [n_data_bits-1:0] b;
   logic                   pbit;
   logic                   rx_s;

   uart_rx_deframer_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         pbit         <= 1'b0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         parity_err   <= 1'b0;
         framing_err  <= 1'b0;
         break_det    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (state)
            // start detection is not tick-gated, so the edge is caught at clk resolution
            ST_IDLE: if (!rx_s) begin
               s     <= '0;
               state <= ST_START;
               busy  <= 1'b1;
            end
            ST_START: if (s_tick) begin
               if (s == S_MID) begin
                  if (!rx_s) begin
                     s     <= '0;
                     n     <= '0;
                     state <= ST_DATA;
                  end else begin
                     // low pulse shorter than half a bit: glitch
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  s <= s + 1'b1;
               end
            end
            ST_DATA: if (s_tick) begin
               if (s == S_LAST_BIT) begin
                  s <= '0;
                  b <= {rx_s, b[n_data_bits-1:1]};
                  if (n == N_LAST) state <= parity_en ? ST_PARITY : ST_STOP;
                  else             n     <= n + 1'b1;
               end else begin
                  s <= s + 1'b1;
               end
            end
            ST_PARITY: if (s_tick) begin
               if (s == S_LAST_BIT) begin
                  s     <= '0;
                  pbit  <= rx_s;
                  state <= ST_STOP;
               end else begin
                  s <= s + 1'b1;
               end
            end
            ST_STOP: if (s_tick) begin
               if (s == S_LAST_STOP) begin
                  s            <= '0;
                  dout         <= b;
                  rx_done_tick <= 1'b1;
                  framing_err  <= ~rx_s;
                  parity_err   <= parity_en & (^b ^ pbit ^ parity_odd);
                  break_det    <= (b == '0) & ~rx_s & (~pbit | ~parity_en);
                  if (rx_s) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     // line still low: wait for it to return high before rearming
                     state <= ST_WAIT_HIGH;
                  end
               end else begin
                  s <= s + 1'b1;
               end
            end
            ST_WAIT_HIGH: if (rx_s) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: an 8N1 instance and an 8E1 instance, each on
// its own serial line. Expected results per frame are derived from the frame
// content (data byte, parity bit, stop level) and queued; a monitor pops one
// entry per rx_done_tick.
module tb_uart_rx_deframer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic       rx = 1'b1;
   logic       rx_p = 1'b1;
   logic [7:0] dout, dout_p;
   logic       done, done_p, perr, perr_p, ferr, ferr_p, brk, brk_p, busy, busy_p;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int tdiv = 0;

   localparam int BIT_CLK = 64;

   typedef struct {
      logic [7:0] d;
      bit         pe, fe, bk;
      int         t0;
      int         ticks;
   } exp_t;

   exp_t exp_q[$];
   exp_t expp_q[$];

   uart_rx_deframer dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
      .dout(dout), .rx_done_tick(done), .parity_err(perr),
      .framing_err(ferr), .break_det(brk), .busy(busy)
   );

   uart_rx_deframer #(.n_data_bits(8), .sb_ticks(16), .parity_en(1'b1), .parity_odd(1'b0)) dut_p (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
      .dout(dout_p), .rx_done_tick(done_p), .parity_err(perr_p),
      .framing_err(ferr_p), .break_det(brk_p), .busy(busy_p)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // tick every 4 clk, driven away from the active edge
   always @(negedge clk) begin
      tdiv   = (tdiv + 1) % 4;
      s_tick = (tdiv == 0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic line(input bit par, input logic v);
      if (par) rx_p = v;
      else     rx   = v;
   endtask

   task automatic wait_clk(input int k);
      repeat (k) @(negedge clk);
   endtask

   // one frame: start, 8 data LSB first, optional parity bit, stop at stop_v
   task automatic send(input bit par, input logic [7:0] d, input logic pbit, input logic stop_v);
      exp_t e;
      e.d     = d;
      e.fe    = !stop_v;
      e.pe    = par && ((($countones(d) + int'(pbit)) % 2) != 0);
      e.bk    = (d == 8'h00) && !stop_v && (!par || !pbit);
      e.t0    = cyc;
      e.ticks = 16 * (1 + 8 + int'(par)) - 8 + 16;
      if (par) expp_q.push_back(e);
      else     exp_q.push_back(e);
      line(par, 1'b0);
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         line(par, d[i]);
         wait_clk(BIT_CLK);
      end
      if (par) begin
         line(par, pbit);
         wait_clk(BIT_CLK);
      end
      line(par, stop_v);
      wait_clk(BIT_CLK);
      line(par, 1'b1);
   endtask

   function automatic logic even_pbit(input logic [7:0] d);
      return logic'($countones(d) % 2);
   endfunction

   // scoreboards
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int   dt;
      if (done) begin
         chk("pulse_width", 32'(prev_done), 0);
         if (exp_q.size() == 0) begin
            chk("spurious_pulse", 1, 0);
         end else begin
            e  = exp_q.pop_front();
            dt = cyc - e.t0;
            chk("dout", 32'(dout), 32'(e.d));
            chk("parity_err", 32'(perr), 32'(e.pe));
            chk("framing_err", 32'(ferr), 32'(e.fe));
            chk("break_det", 32'(brk), 32'(e.bk));
            chk("frame_latency_ok", 32'(dt >= 4 * e.ticks - 2 && dt <= 4 * e.ticks + 6), 1);
            if (!e.fe) chk("busy_drop", 32'(busy), 0);
         end
      end
      prev_done = done;
   end

   logic prev_done_p = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int   dt;
      if (done_p) begin
         chk("p_pulse_width", 32'(prev_done_p), 0);
         if (expp_q.size() == 0) begin
            chk("p_spurious_pulse", 1, 0);
         end else begin
            e  = expp_q.pop_front();
            dt = cyc - e.t0;
            chk("p_dout", 32'(dout_p), 32'(e.d));
            chk("p_parity_err", 32'(perr_p), 32'(e.pe));
            chk("p_framing_err", 32'(ferr_p), 32'(e.fe));
            chk("p_break_det", 32'(brk_p), 32'(e.bk));
            chk("p_frame_latency_ok", 32'(dt >= 4 * e.ticks - 2 && dt <= 4 * e.ticks + 6), 1);
            if (!e.fe) chk("p_busy_drop", 32'(busy_p), 0);
         end
      end
      prev_done_p = done_p;
   end

   initial begin
      logic [7:0] d;
      logic       sv, pb;

      // reset state
      wait_clk(4);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_perr", 32'(perr), 0);
      chk("rst_ferr", 32'(ferr), 0);
      chk("rst_brk", 32'(brk), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      wait_clk(20);

      // 8N1 back-to-back stream
      send(1'b0, 8'hA5, 1'b0, 1'b1);
      send(1'b0, 8'd100, 1'b0, 1'b1);
      send(1'b0, 8'd150, 1'b0, 1'b1);
      send(1'b0, 8'd200, 1'b0, 1'b1);
      wait_clk(BIT_CLK);
      chk("stream_all_received", 32'(exp_q.size()), 0);

      // glitch: 5 ticks low
      rx = 1'b0;
      wait_clk(12);
      chk("glitch_busy_high", 32'(busy), 1);
      wait_clk(8);
      rx = 1'b1;
      wait_clk(28);
      chk("glitch_busy_low", 32'(busy), 0);
      wait_clk(4 * BIT_CLK);

      // bad stop bit, then line high two bit times later, then a clean frame
      send(1'b0, 8'h3C, 1'b0, 1'b0);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      send(1'b0, 8'h11, 1'b0, 1'b1);
      wait_clk(BIT_CLK);

      // break: 12 bit times low, exactly one pulse
      begin
         exp_t e;
         e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1; e.bk = 1'b1;
         e.t0 = cyc; e.ticks = 152;
         exp_q.push_back(e);
      end
      rx = 1'b0;
      wait_clk(12 * BIT_CLK);
      chk("break_one_pulse", 32'(exp_q.size()), 0);
      rx = 1'b1;
      wait_clk(3 * BIT_CLK);

      // even parity: good then bad parity bit
      send(1'b1, 8'h07, 1'b1, 1'b1);
      send(1'b1, 8'h07, 1'b0, 1'b1);
      wait_clk(BIT_CLK);
      chk("parity_all_received", 32'(expp_q.size()), 0);

      // reset during data bit 3 of 0xF0
      rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 3; i++) begin
         rx = (8'hF0 >> i) & 1'b1;
         wait_clk(BIT_CLK);
      end
      rx = 1'b0;
      wait_clk(BIT_CLK / 2);
      reset = 1'b1;
      rx = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      chk("midrst_dout", 32'(dout), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_ferr", 32'(ferr), 0);
      chk("midrst_brk", 32'(brk), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_dout_p", 32'(dout_p), 0);
      chk("midrst_perr_p", 32'(perr_p), 0);
      wait_clk(12 * BIT_CLK);
      send(1'b0, 8'h55, 1'b0, 1'b1);
      wait_clk(BIT_CLK);

      // randomized 8N1 frames with random gaps and occasional bad stop
      for (int k = 0; k < 20; k++) begin
         d  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'h00;
         sv = ($urandom_range(0, 3) != 0);
         send(1'b0, d, 1'b0, sv);
         if (!sv) wait_clk(BIT_CLK);
         wait_clk($urandom_range(0, 70));
      end

      // randomized parity frames
      for (int k = 0; k < 10; k++) begin
         d  = 8'($urandom);
         pb = ($urandom_range(0, 1) == 1) ? even_pbit(d) : ~even_pbit(d);
         sv = ($urandom_range(0, 4) != 0);
         send(1'b1, d, pb, sv);
         if (!sv) wait_clk(BIT_CLK);
         wait_clk($urandom_range(0, 70));
      end

      // bounded drain of any outstanding expectations
      for (int i = 0; i < 3000 && (exp_q.size() + expp_q.size()) != 0; i++) wait_clk(1);
      chk("drain_pending", 32'(exp_q.size() + expp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
